// File: rtl/onehot_decoder_pkg.sv
// Shared types, widths and the code-to-one-hot helper for the one-hot pulse decoder.
package onehot_decoder_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  function automatic logic [OUT_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder_hold_timer.sv
// hold_timer: down-counter that loads HOLD-1, decrements toward zero and flags terminal count.
module hold_timer
  import onehot_decoder_pkg::*;
#(
  parameter int unsigned HOLD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = RELOAD;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/onehot_pulse_decoder.sv
// One-hot pulse decoder: accepted 3-bit code drives a one-hot output for HOLD cycles.
// Optional one-entry pending-code register compiled in with ONEHOT_DECODER_QUEUE_EN.
//
// state | meaning
// IDLE  | output zero, waiting for a qualified request
// DRIVE | one-hot output held while the hold timer counts down
module onehot_pulse_decoder
  import onehot_decoder_pkg::*;
#(
  parameter int unsigned HOLD = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [CODE_W-1:0] y_i,
  input  logic              done_i,
  output logic              ready_o,
  output logic [OUT_W-1:0]  out_o,
  output logic              busy_o
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             busy_q;
  logic             tmr_load, tmr_dec, tmr_clr, tmr_zero;
  logic             accept;

`ifdef ONEHOT_DECODER_QUEUE_EN
  logic              q_valid_q, q_valid_d;
  logic [CODE_W-1:0] q_code_q, q_code_d;

  assign ready_o = ~rst_i & ~en_i & ((state_q == IDLE) | ~q_valid_q);
`else
  assign ready_o = ~rst_i & ~en_i & (state_q == IDLE);
`endif

  assign accept = done_i & ready_o;

  hold_timer #(
    .HOLD(HOLD)
  ) u_hold_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tmr_clr),
    .load_i(tmr_load),
    .dec_i (tmr_dec),
    .zero_o(tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_clr  = 1'b0;
`ifdef ONEHOT_DECODER_QUEUE_EN
    q_valid_d = q_valid_q;
    q_code_d  = q_code_q;
`endif
    if (en_i) begin
      state_d = IDLE;
      out_d   = '0;
      tmr_clr = 1'b1;
`ifdef ONEHOT_DECODER_QUEUE_EN
      q_valid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d  = DRIVE;
            out_d    = code_to_onehot(y_i);
            tmr_load = 1'b1;
          end
        end
        DRIVE: begin
          if (!tmr_zero) begin
            tmr_dec = 1'b1;
`ifdef ONEHOT_DECODER_QUEUE_EN
            if (accept) begin
              q_valid_d = 1'b1;
              q_code_d  = y_i;
            end
`endif
          end else begin
`ifdef ONEHOT_DECODER_QUEUE_EN
            // Chain the next code straight in so the output never drops to zero.
            if (q_valid_q) begin
              out_d     = code_to_onehot(q_code_q);
              tmr_load  = 1'b1;
              q_valid_d = 1'b0;
            end else if (accept) begin
              out_d    = code_to_onehot(y_i);
              tmr_load = 1'b1;
            end else begin
              state_d = IDLE;
              out_d   = '0;
            end
`else
            state_d = IDLE;
            out_d   = '0;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          out_d   = '0;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      out_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= (out_d != '0);
    end
  end

`ifdef ONEHOT_DECODER_QUEUE_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_valid_q <= 1'b0;
      q_code_q  <= '0;
    end else begin
      q_valid_q <= q_valid_d;
      q_code_q  <= q_code_d;
    end
  end
`endif

  assign out_o  = out_q;
  assign busy_o = busy_q;

endmodule

// File: doc/onehot_pulse_decoder.md
ONEHOT_PULSE_DECODER -- requirements
Module: onehot_pulse_decoder

Interface
REQ-001 The block SHALL have one parameter: HOLD, default 4, number of cycles a decoded one-hot output is held (legal 1..255).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 EN  input  1  active-low enable; 1 = block disabled.
REQ-006 Y  input  3  binary index to decode (0..7).
REQ-007 Done  input  1  Y valid qualifier; request present when 1.
REQ-008 READY  output  1  block can accept a request this cycle.
REQ-009 OUT  output  8  registered one-hot decode of the accepted Y; all-zero when idle.
REQ-010 BUSY  output  1  registered; 1 while OUT is non-zero.

Function
REQ-011 The block SHALL have states IDLE and DRIVE, plus an 8-bit down-counter CNT.
REQ-012 READY SHALL be combinational: ~EN & (state==IDLE), extended per REQ-024 when the queue is compiled in.
REQ-013 A request SHALL be accepted on a rising edge where Done & READY; otherwise Done and Y are ignored, with nothing stored.
REQ-014 On acceptance in IDLE, the next cycle SHALL have OUT = 1<<Y, BUSY=1, state=DRIVE, CNT=HOLD-1 (1-cycle latency).
REQ-015 In DRIVE with CNT!=0, CNT SHALL decrement by 1 each cycle with OUT unchanged.
REQ-016 In DRIVE with CNT==0 and no pending code, the next cycle SHALL be IDLE, OUT=0, BUSY=0; OUT is therefore non-zero for exactly HOLD cycles.
REQ-017 HOLD=1 SHALL produce a single-cycle OUT pulse and a return to IDLE on the following cycle.
REQ-018 EN=1 in any state SHALL abort: next cycle IDLE, OUT=0, BUSY=0, CNT=0, queue flushed; no request is accepted while EN=1.
REQ-019 OUT SHALL never have more than one bit set.

Reset
REQ-020 RST=1 SHALL on the next edge force IDLE, OUT=8'h00, BUSY=0, CNT=0, queue empty, overriding all other inputs including an in-progress hold.
REQ-021 READY SHALL be 0 during any cycle in which RST=1.

Configuration
REQ-022 Macro ONEHOT_DECODER_QUEUE_EN SHALL compile in a one-entry pending-code register.
REQ-023 Without the macro, READY SHALL be 0 throughout DRIVE, and Done in DRIVE SHALL be ignored.
REQ-024 With the macro, READY SHALL equal ~EN & (IDLE | queue empty); a request accepted in DRIVE SHALL be stored in the queue.
REQ-025 With the macro, at CNT==0 with the queue full, the next cycle SHALL load the queued code: OUT = 1<<queued Y, CNT=HOLD-1, queue emptied, with no zero gap on OUT.
REQ-026 With the macro, a request accepted on the CNT==0 cycle with the queue empty SHALL bypass the queue and take effect exactly as in REQ-025.

Structure
REQ-027 Package onehot_decoder_pkg SHALL hold the state enum (IDLE, DRIVE), CODE_W=3, OUT_W=8, CNT_W=8, and a code-to-one-hot function.
REQ-028 The CNT load/decrement/zero-detect SHALL be a sub-module named hold_timer.

Verification
REQ-029 Reset with Done=1, Y=5 held: OUT=0, BUSY=0, READY=0 during reset; after release, OUT=8'h20 one cycle after the first accepting edge.
REQ-030 HOLD=4, EN=0, single Done pulse with Y=0: OUT=8'h01 for exactly 4 cycles, then 8'h00, BUSY tracking OUT.
REQ-031 HOLD=1, back-to-back Done with Y=7 then Y=3 (no macro): OUT=8'h80 for 1 cycle, 8'h00 for 1 cycle, then 8'h08; the second request waits for READY.
REQ-032 EN raised on cycle 2 of a HOLD=4 Y=2 hold: OUT goes to 8'h00 next cycle, READY=0 while EN=1, and Done is ignored.
REQ-033 With the macro, HOLD=3, Y=1 accepted and then Y=6 presented during DRIVE: OUT=8'h02 for 3 cycles immediately followed by 8'h40 for 3 cycles; a third request while the queue is full sees READY=0.
REQ-034 Sweep of Y=0..7: OUT equals 1<<Y each time, and OUT is never multi-hot on any cycle.
